// File: rtl/selectio_word_align.sv
// selectio_word_align: per-lane word-alignment controller for the select_io deserialiser.
// Each lane bitslips its ISERDES until TRAIN_PAT is seen MATCH_CNT times in a row.
module selectio_word_align #(
  parameter int                 DW        = 4,
  parameter int                 SP_Mult   = 4,
  parameter logic [SP_Mult-1:0] TRAIN_PAT = 4'hC,
  parameter int                 MATCH_CNT = 8,
  parameter int                 SLIP_WAIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_train_en,
  input  logic [DW*SP_Mult-1:0] i_pardata,
  output logic [DW-1:0]         o_bitslip,
  output logic [DW-1:0]         o_lane_lock,
  output logic [DW-1:0]         o_align_err,
  output logic                  o_align_done,
  output logic [DW*SP_Mult-1:0] o_data,
  output logic                  o_data_vld
);

  localparam int SCW = $clog2(SP_Mult) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_SLIP   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_LOCKED = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;

  localparam logic [7:0]     MATCH_LIM = 8'(MATCH_CNT);
  localparam logic [SCW-1:0] SLIP_LIM  = SCW'(SP_Mult);
  localparam logic [3:0]     WAIT_LIM  = 4'(SLIP_WAIT - 1);

  logic                  train_prev_q, train_prev_d;
  logic                  align_done_q, align_done_d;
  logic                  data_vld_q, data_vld_d;
  logic [DW*SP_Mult-1:0] data_q, data_d;
  logic                  restart;

  // A fresh rising edge of the training window restarts every lane from scratch.
  assign restart = i_train_en & ~train_prev_q;

  for (genvar l = 0; l < DW; l++) begin : g_lane
    logic [2:0]         state_q, state_d;
    logic [7:0]         match_cnt_q, match_cnt_d;
    logic [SCW-1:0]     slip_cnt_q, slip_cnt_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic               bitslip_q, bitslip_d;
    logic               lock_q, lock_d;
    logic               err_q, err_d;
    logic [SP_Mult-1:0] word;
    logic               hit;

    assign word = i_pardata[l*SP_Mult +: SP_Mult];
    assign hit  = (word == TRAIN_PAT);

    always_comb begin
      state_d     = state_q;
      match_cnt_d = match_cnt_q;
      slip_cnt_d  = slip_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      if (restart) begin
        state_d     = S_CHECK;
        match_cnt_d = '0;
        slip_cnt_d  = '0;
        wait_cnt_d  = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            match_cnt_d = '0;
            slip_cnt_d  = '0;
            wait_cnt_d  = '0;
            if (i_train_en) state_d = S_CHECK;
          end
          S_CHECK: begin
            if (!i_train_en) begin
              state_d = S_IDLE;
            end else if (hit) begin
              match_cnt_d = match_cnt_q + 8'd1;
              if (match_cnt_d == MATCH_LIM) state_d = S_LOCKED;
            end else begin
              match_cnt_d = '0;
              state_d     = (slip_cnt_q == SLIP_LIM) ? S_FAIL : S_SLIP;
            end
          end
          S_SLIP: begin
            if (!i_train_en) begin
              state_d = S_IDLE;
            end else begin
              slip_cnt_d = slip_cnt_q + 1'b1;
              wait_cnt_d = '0;
              state_d    = S_WAIT;
            end
          end
          S_WAIT: begin
            if (!i_train_en) begin
              state_d = S_IDLE;
            end else if (wait_cnt_q == WAIT_LIM) begin
              wait_cnt_d = '0;
              state_d    = S_CHECK;
            end else begin
              wait_cnt_d = wait_cnt_q + 4'd1;
            end
          end
          S_LOCKED: state_d = S_LOCKED;
          S_FAIL: begin
            if (!i_train_en) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    // Pulse and error flops follow the next state so a restart cancels them in the same edge.
    always_comb begin
      bitslip_d = (state_d == S_SLIP);
      err_d     = (state_d == S_FAIL);
      lock_d    = (state_q == S_LOCKED) & ~restart;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        state_q     <= S_IDLE;
        match_cnt_q <= '0;
        slip_cnt_q  <= '0;
        wait_cnt_q  <= '0;
        bitslip_q   <= 1'b0;
        lock_q      <= 1'b0;
        err_q       <= 1'b0;
      end else begin
        state_q     <= state_d;
        match_cnt_q <= match_cnt_d;
        slip_cnt_q  <= slip_cnt_d;
        wait_cnt_q  <= wait_cnt_d;
        bitslip_q   <= bitslip_d;
        lock_q      <= lock_d;
        err_q       <= err_d;
      end
    end

    assign o_bitslip[l]   = bitslip_q;
    assign o_lane_lock[l] = lock_q;
    assign o_align_err[l] = err_q;
  end

  always_comb begin
    train_prev_d = i_train_en;
    align_done_d = &o_lane_lock;
    data_d       = i_pardata;
    data_vld_d   = align_done_q & ~i_train_en;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      train_prev_q <= 1'b0;
      align_done_q <= 1'b0;
      data_q       <= '0;
      data_vld_q   <= 1'b0;
    end else begin
      train_prev_q <= train_prev_d;
      align_done_q <= align_done_d;
      data_q       <= data_d;
      data_vld_q   <= data_vld_d;
    end
  end

  assign o_align_done = align_done_q;
  assign o_data       = data_q;
  assign o_data_vld   = data_vld_q;

endmodule

// File: tb/tb_selectio_word_align.sv
// tb_selectio_word_align: directed and randomized alignment scenarios against a lane/ISERDES model.
// Expected event cycles come from the slip-cost arithmetic, not from the controller's state machine.
module tb_selectio_word_align;

  localparam int         DW     = 4;
  localparam int         SP     = 4;
  localparam int         MC     = 8;
  localparam int         SW     = 4;
  localparam logic [3:0] PAT    = 4'hC;
  localparam int         PERIOD = 2 + SW;
  localparam int         WIN    = 40;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [DW*SP-1:0]   pardata;
  logic [DW-1:0]      o_bitslip, o_lane_lock, o_align_err;
  logic               o_align_done, o_data_vld;
  logic [DW*SP-1:0]   o_data;

  always #5 clk = ~clk;

  selectio_word_align #(
    .DW(DW), .SP_Mult(SP), .TRAIN_PAT(PAT), .MATCH_CNT(MC), .SLIP_WAIT(SW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_train_en(en), .i_pardata(pardata),
    .o_bitslip(o_bitslip), .o_lane_lock(o_lane_lock), .o_align_err(o_align_err),
    .o_align_done(o_align_done), .o_data(o_data), .o_data_vld(o_data_vld)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Lane model: each lane shows TRAIN_PAT rotated by (offset + slips seen), or a constant 5.
  int  off[DW];
  int  slips[DW];
  bit  fail_lane[DW];
  bit  rot_en;
  int  corrupt_lane;
  int  corrupt_edge;
  bit  use_raw;
  bit  chk_data;
  int  edge_idx;

  int  pulse_cnt[DW], first_pulse[DW], last_pulse[DW];
  int  lock_edge[DW], err_edge[DW];
  bit  lock_drop[DW];
  int  done_edge, vld_edge;

  function automatic logic [3:0] rotl(input logic [3:0] w, input int n);
    logic [7:0] d;
    d = {w, w} << (n % 4);
    return d[7:4];
  endfunction

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    for (int l = 0; l < DW; l++) slips[l] = 0;
    corrupt_lane = -1;
    corrupt_edge = -1;
    rot_en       = 1'b1;
  endtask

  task automatic driveLanes();
    logic [3:0] w;
    for (int l = 0; l < DW; l++) begin
      if (fail_lane[l]) w = 4'h5;
      else w = rotl(PAT, off[l] + (rot_en ? slips[l] : 0));
      if (l == corrupt_lane && edge_idx + 1 == corrupt_edge) w = ~w;
      pardata[l*SP +: SP] = w;
    end
  endtask

  task automatic beginWindow();
    edge_idx  = -1;
    done_edge = -1;
    vld_edge  = -1;
    for (int l = 0; l < DW; l++) begin
      pulse_cnt[l]   = 0;
      first_pulse[l] = -1;
      last_pulse[l]  = -1;
      lock_edge[l]   = -1;
      err_edge[l]    = -1;
      lock_drop[l]   = 1'b0;
    end
  endtask

  task automatic record();
    for (int l = 0; l < DW; l++) begin
      if (o_bitslip[l]) begin
        pulse_cnt[l]++;
        if (first_pulse[l] < 0) first_pulse[l] = edge_idx;
        last_pulse[l] = edge_idx;
      end
      if (o_lane_lock[l] && lock_edge[l] < 0) lock_edge[l] = edge_idx;
      if (!o_lane_lock[l] && lock_edge[l] >= 0) lock_drop[l] = 1'b1;
      if (o_align_err[l] && err_edge[l] < 0) err_edge[l] = edge_idx;
    end
    // Done lags lock by a cycle, so the stale value right after a restart edge is skipped.
    if (o_align_done && done_edge < 0 && edge_idx >= 2) done_edge = edge_idx;
    if (o_data_vld && vld_edge < 0) vld_edge = edge_idx;
  endtask

  task automatic applyStimulus(input int n);
    logic [DW-1:0]    bs;
    logic [DW*SP-1:0] sent;
    for (int k = 0; k < n; k++) begin
      if (!use_raw) driveLanes();
      sent = pardata;
      bs   = o_bitslip;
      @(posedge clk);
      #1;
      edge_idx++;
      for (int l = 0; l < DW; l++) if (bs[l]) slips[l]++;
      record();
      if (chk_data) checkOutput("data_latency", longint'(o_data), longint'(sent));
    end
  endtask

  task automatic startTraining();
    en = 1'b0;
    applyStimulus(2);
    en = 1'b1;
    beginWindow();
  endtask

  task automatic checkAlign(input string name);
    int n_slip;
    int lk;
    int worst;
    bit any_fail;
    worst    = 0;
    any_fail = 1'b0;
    for (int l = 0; l < DW; l++) begin
      if (fail_lane[l]) begin
        n_slip   = SP;
        any_fail = 1'b1;
        checkOutput($sformatf("%s_l%0d_err_edge", name, l), err_edge[l], 1 + SP*PERIOD);
        checkOutput($sformatf("%s_l%0d_lock_edge", name, l), lock_edge[l], -1);
      end else begin
        n_slip = (SP - off[l]) % SP;
        lk     = 1 + n_slip*PERIOD + MC;
        if (lk > worst) worst = lk;
        checkOutput($sformatf("%s_l%0d_lock_edge", name, l), lock_edge[l], lk);
        checkOutput($sformatf("%s_l%0d_err_edge", name, l), err_edge[l], -1);
      end
      checkOutput($sformatf("%s_l%0d_pulses", name, l), pulse_cnt[l], n_slip);
      if (n_slip > 0) begin
        checkOutput($sformatf("%s_l%0d_first_pulse", name, l), first_pulse[l], 1);
        checkOutput($sformatf("%s_l%0d_last_pulse", name, l), last_pulse[l],
                    1 + (n_slip - 1)*PERIOD);
      end
    end
    checkOutput($sformatf("%s_done_edge", name), done_edge, any_fail ? -1 : worst + 1);
  endtask

  task automatic setLanes(input int o0, input int o1, input int o2, input int o3,
                          input logic [3:0] fmask);
    off[0] = o0; off[1] = o1; off[2] = o2; off[3] = o3;
    for (int l = 0; l < DW; l++) fail_lane[l] = fmask[l];
    resetModel();
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    pardata  = '0;
    use_raw  = 1'b0;
    chk_data = 1'b0;
    edge_idx = 0;
    setLanes(0, 0, 0, 0, 4'h0);
    beginWindow();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_bitslip", longint'(o_bitslip), 0);
    checkOutput("rst_lock", longint'(o_lane_lock), 0);
    checkOutput("rst_err", longint'(o_align_err), 0);
    checkOutput("rst_done", longint'(o_align_done), 0);
    checkOutput("rst_data", longint'(o_data), 0);
    checkOutput("rst_vld", longint'(o_data_vld), 0);
    rst = 1'b0;

    $display("[TB] all lanes pre-aligned");
    setLanes(0, 0, 0, 0, 4'h0);
    startTraining();
    applyStimulus(WIN);
    checkAlign("aligned");

    $display("[TB] lane 2 rotated by two");
    setLanes(0, 0, 2, 0, 4'h0);
    startTraining();
    applyStimulus(WIN);
    checkAlign("lane2_rot2");
    checkOutput("vld_low_while_training", longint'(o_data_vld), 0);

    $display("[TB] payload forwarding after lock");
    en       = 1'b0;
    use_raw  = 1'b1;
    chk_data = 1'b1;
    pardata  = 16'h1234;
    beginWindow();
    applyStimulus(1);
    checkOutput("vld_after_drop", longint'(o_data_vld), 1);
    for (int k = 0; k < 6; k++) begin
      pardata = 16'($urandom);
      applyStimulus(1);
    end
    checkOutput("vld_edge", vld_edge, 0);
    checkOutput("lock_held_payload", longint'(o_lane_lock), 15);
    checkOutput("done_held_payload", longint'(o_align_done), 1);
    chk_data = 1'b0;
    use_raw  = 1'b0;

    $display("[TB] corrupted word on a locked lane");
    setLanes(0, 0, 0, 0, 4'h0);
    corrupt_lane = 1;
    corrupt_edge = 22;
    startTraining();
    applyStimulus(WIN);
    checkAlign("locked_glitch");
    checkOutput("locked_glitch_no_drop", lock_drop[1], 0);

    $display("[TB] corrupted word at match 5");
    setLanes(0, 0, 0, 0, 4'h0);
    rot_en       = 1'b0;
    corrupt_lane = 3;
    corrupt_edge = 5;
    startTraining();
    applyStimulus(WIN);
    checkOutput("midcheck_pulses", pulse_cnt[3], 1);
    checkOutput("midcheck_pulse_edge", first_pulse[3], 5);
    checkOutput("midcheck_lock_edge", lock_edge[3], 5 + PERIOD + MC);
    checkOutput("midcheck_other_lock", lock_edge[0], 1 + MC);
    checkOutput("midcheck_done_edge", done_edge, 5 + PERIOD + MC + 1);

    for (int r = 0; r < 3; r++) begin
      $display("[TB] random offsets round %0d", r);
      setLanes(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 4'h0);
      if (r == 2) fail_lane[$urandom_range(0, 3)] = 1'b1;
      startTraining();
      applyStimulus(WIN);
      checkAlign($sformatf("random%0d", r));
    end

    $display("[TB] lane 0 never matches");
    setLanes(0, 0, 0, 0, 4'h1);
    startTraining();
    applyStimulus(WIN);
    checkAlign("fail_lane0");
    en = 1'b0;
    applyStimulus(1);
    checkOutput("err_cleared_on_drop", longint'(o_align_err), 0);
    checkOutput("done_low_after_fail", longint'(o_align_done), 0);

    $display("[TB] restart while lane 0 waits after a slip");
    setLanes(0, 0, 0, 0, 4'h1);
    startTraining();
    applyStimulus(3);
    checkOutput("restart_pre_pulse", pulse_cnt[0], 1);
    en = 1'b0;
    applyStimulus(1);
    en = 1'b1;
    beginWindow();
    applyStimulus(WIN);
    checkAlign("restart");

    $display("[TB] asynchronous reset during check");
    setLanes(0, 0, 0, 0, 4'h0);
    startTraining();
    applyStimulus(4);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_data", longint'(o_data), 0);
    checkOutput("arst_lock", longint'(o_lane_lock), 0);
    checkOutput("arst_bitslip", longint'(o_bitslip), 0);
    checkOutput("arst_err", longint'(o_align_err), 0);
    checkOutput("arst_done", longint'(o_align_done), 0);
    checkOutput("arst_vld", longint'(o_data_vld), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
